// File: rtl/rle_encoder_z.sv
// Zero-run-length encoder: turns a serial block of signed coefficients into (run, level, eob) tokens.
// Optional build macro RLE_STATS_EN adds stat_coefs/stat_tokens counters.
module rle_encoder_z #(
  parameter int DATA_W    = 19,
  parameter int RUN_W     = 4,
  parameter int BLOCK_LEN = 8,
  parameter int MAX_RUN   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_level,
  output logic              out_eob
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]       stat_coefs,
  output logic [31:0]       stat_tokens
`endif
);

  localparam int POS_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t        state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [POS_W-1:0]  pos_cnt, pos_nxt;
  logic              accept, last, emit;
  logic [RUN_W-1:0]  tok_run;
  logic [DATA_W-1:0] tok_level;
  logic              tok_eob;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign last      = (pos_cnt == POS_W'(BLOCK_LEN - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    emit      = 1'b0;
    tok_run   = run_cnt;
    tok_level = in_data;
    tok_eob   = last;
    run_nxt   = run_cnt;
    pos_nxt   = pos_cnt;
    state_nxt = state;

    if (accept) begin
      pos_nxt = last ? '0 : pos_cnt + POS_W'(1);
      if (in_data != '0) begin
        emit    = 1'b1;
        run_nxt = '0;
      end else if (last) begin
        // EOB counts the closing zero itself
        emit      = 1'b1;
        tok_run   = run_cnt + RUN_W'(1);
        tok_level = '0;
        tok_eob   = 1'b1;
        run_nxt   = '0;
      end else if (run_cnt == RUN_W'(MAX_RUN)) begin
        emit      = 1'b1;
        tok_run   = RUN_W'(MAX_RUN);
        tok_level = '0;
        tok_eob   = 1'b0;
        run_nxt   = '0;
      end else begin
        run_nxt = run_cnt + RUN_W'(1);
      end
    end

    // A drain and a load in the same cycle keeps the register FULL
    if (emit)
      state_nxt = FULL;
    else if (out_valid && out_ready)
      state_nxt = EMPTY;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      run_cnt <= '0;
      pos_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      pos_cnt <= pos_nxt;
    end
  end

  // NOTE: the token register is reset too, since its zero value is visible on the outputs after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_run   <= '0;
      out_level <= '0;
      out_eob   <= 1'b0;
    end else if (emit) begin
      out_run   <= tok_run;
      out_level <= tok_level;
      out_eob   <= tok_eob;
    end
  end

`ifdef RLE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_coefs  <= '0;
      stat_tokens <= '0;
    end else begin
      if (accept)
        stat_coefs <= stat_coefs + 32'd1;
      if (out_valid && out_ready)
        stat_tokens <= stat_tokens + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_encoder_z.sv
// Directed bench for rle_encoder_z: default instance plus a MAX_RUN=3 instance sharing the same stimulus.
module tb_rle_encoder_z;

  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;

  logic          in_ready, out_valid, out_eob;
  logic [3:0]    out_run;
  logic [DW-1:0] out_level;
  logic          in_ready3, out_valid3, out_eob3;
  logic [3:0]    out_run3;
  logic [DW-1:0] out_level3;
`ifdef RLE_STATS_EN
  logic [31:0]   stat_coefs, stat_tokens, stat_coefs3, stat_tokens3;
`endif

  int total = 0;
  int bad   = 0;
  logic [23:0] q[$];
  logic [23:0] q3[$];

  always #5 clk = ~clk;

  rle_encoder_z u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run),
    .out_level(out_level), .out_eob(out_eob)
`ifdef RLE_STATS_EN
    , .stat_coefs(stat_coefs), .stat_tokens(stat_tokens)
`endif
  );

  rle_encoder_z #(.MAX_RUN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_run(out_run3),
    .out_level(out_level3), .out_eob(out_eob3)
`ifdef RLE_STATS_EN
    , .stat_coefs(stat_coefs3), .stat_tokens(stat_tokens3)
`endif
  );

  // Handshakes are stable at the falling edge and complete at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)  q.push_back({out_run, out_level, out_eob});
    if (!rst && out_valid3 && out_ready) q3.push_back({out_run3, out_level3, out_eob3});
  end

  function automatic logic [23:0] tok(input int r, input int l, input bit e);
    return {4'(r), 19'(l), e};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_tok(input string tag, input logic [23:0] exp);
    logic [23:0] got;
    got = (q.size() > 0) ? q.pop_front() : 'x;
    check(tag, {8'd0, got}, {8'd0, exp});
  endtask

  task automatic check_tok3(input string tag, input logic [23:0] exp);
    logic [23:0] got;
    got = (q3.size() > 0) ? q3.pop_front() : 'x;
    check(tag, {8'd0, got}, {8'd0, exp});
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      bad++;
      $error("FAIL send_timeout: got=in_ready stuck low want=accept");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_run",   {28'd0, out_run},   32'd0);
    check("rst_out_level", {13'd0, out_level}, 32'd0);
    check("rst_out_eob",   {31'd0, out_eob},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;

    // Test 1: 5,0,0,-3,0,0,0,0
    send(5); send(0); send(0); send(-3); send(0); send(0); send(0); send(0);
    idle(3);
    check("t1_count", q.size(), 3);
    check_tok("t1_tok0", tok(0, 5, 0));
    check_tok("t1_tok1", tok(2, -3, 0));
    check_tok("t1_tok2", tok(4, 0, 1));

    // Test 2: 1..8
    for (int k = 1; k <= 8; k++) send(DW'(k));
    idle(3);
    check("t2_count", q.size(), 8);
    for (int k = 1; k <= 7; k++) check_tok("t2_tok", tok(0, k, 0));
    check_tok("t2_tok_last", tok(0, 8, 1));

    // Most negative level passes through unchanged; seven trailing zeros give EOB run 7
    send(19'h40000);
    for (int k = 0; k < 7; k++) send(0);
    idle(3);
    check("neg_count", q.size(), 2);
    check_tok("neg_tok0", {4'd0, 19'h40000, 1'b0});
    check_tok("neg_tok1", tok(7, 0, 1));

    // Test 3: all zeros
    for (int k = 0; k < 8; k++) send(0);
    idle(3);
    check("t3_count", q.size(), 1);
    check_tok("t3_tok", tok(8, 0, 1));

    // Test 4: back-pressure after the first token
    out_ready = 1'b0;
    send(7);
    in_valid = 1'b1;
    in_data  = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_ready", {31'd0, in_ready}, 32'd0);
      check("t4_hold_tok", {8'd0, out_run, out_level, out_eob}, {8'd0, tok(0, 7, 0)});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(0);
    send(9);
    idle(3);
    check("t4_count", q.size(), 2);
    check_tok("t4_tok0", tok(0, 7, 0));
    check_tok("t4_tok1", tok(6, 9, 1));

    // Test 5: escape on the MAX_RUN=3 instance; default instance for comparison
    q3.delete();
    send(0); send(0); send(0); send(0); send(0); send(7); send(0); send(9);
    idle(3);
    check("t5_count3", q3.size(), 3);
    check_tok3("t5_esc", tok(3, 0, 0));
    check_tok3("t5_tok1", tok(1, 7, 0));
    check_tok3("t5_tok2", tok(1, 9, 1));
    check("t5_count", q.size(), 2);
    check_tok("t5_def0", tok(5, 7, 0));
    check_tok("t5_def1", tok(1, 9, 1));

    // Test 6: reset mid-block
    send(4); send(0); send(0);
    in_valid = 1'b0;
    check_tok("t6_pre", tok(0, 4, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) send(0);
    send(2);
    idle(3);
    check("t6_count", q.size(), 1);
    check_tok("t6_tok", tok(7, 2, 1));
`ifdef RLE_STATS_EN
    check("t6_stat_coefs", stat_coefs, 32'd8);
    check("t6_stat_tokens", stat_tokens, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
